// File: rtl/bomb_pkg.sv
// Shared bomb definitions: code length, seed offsets, FSM states and the code derivation.
// Anything that shows or checks the code must call code_digit so the two always agree.
package bomb_pkg;

  localparam int CODE_LEN = 4;

  // Digit i of the code is (seed + OFFSET[i]) mod 10; digit 0 sits in the LSBs.
  localparam logic [4*CODE_LEN-1:0] OFFSET = {4'd9, 4'd6, 4'd3, 4'd0};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ERR     = 3'd3,
    ST_SUCCESS = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  function automatic logic [3:0] code_digit(input logic [4:0] seed, input int i);
    logic [5:0] sum;
    sum = {1'b0, seed} + {2'b00, OFFSET[i*4 +: 4]};
    return 4'(sum % 6'd10);
  endfunction

endpackage

// File: rtl/entry_buffer.sv
// Keypad entry buffer: appends digits in slot order and counts them; clear refills with 4'hF.
// Updates one cycle after push/clr; pushes into a full buffer are dropped.
module entry_buffer
  import bomb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  clr,
  input  logic                  push,
  input  logic [3:0]            digit,
  output logic [2:0]            cnt,
  output logic [4*CODE_LEN-1:0] digits
);

  always_ff @(posedge clk) begin
    if (rst_p || clr) begin
      cnt    <= 3'd0;
      digits <= '1;
    end else if (push && (cnt < 3'(CODE_LEN))) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        if (cnt == 3'(i)) digits[i*4 +: 4] <= digit;
      end
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/passwd_check.sv
// Password stage: latches the code on the start_input rising edge, collects keypad digits,
// checks a full entry in one cycle and drives sticky success/fail levels; no backpressure.
module passwd_check
  import bomb_pkg::*;
#(
  parameter int MAX_TRIES  = 3,
  parameter int ERR_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  start_input,
  input  logic [4:0]            seed,
  input  logic                  timeout,
  input  logic                  key_valid,
  input  logic [3:0]            key_value,
  output logic                  success,
  output logic                  fail,
  output logic                  err,
  output logic [2:0]            entered_cnt,
  output logic [4*CODE_LEN-1:0] entry_digits,
  output logic [1:0]            tries_left
);

  localparam int ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  state_t               state;
  logic                 start_q;
  logic [4*CODE_LEN-1:0] code_q;
  logic [ERR_W-1:0]     err_cnt;

  logic start_rise, armed, arm, live, key_ok;
  logic is_digit, is_clear, match, last_slot;
  logic buf_push, buf_clr, retry;

  always_comb begin
    start_rise = start_input && !start_q;
    armed      = (state == ST_ENTRY) || (state == ST_CHECK) || (state == ST_ERR);
    arm        = start_rise && !armed;
    // Dropping start_input outranks timeout, which outranks keys and the compare.
    live       = armed && start_input && !timeout;
    key_ok     = live && (state == ST_ENTRY) && key_valid;
    is_digit   = (key_value <= 4'd9);
    is_clear   = (key_value == 4'hC);
    match      = (entry_digits == code_q);
    last_slot  = (entered_cnt == 3'(CODE_LEN - 1));
    buf_push   = key_ok && is_digit;
    retry      = live && (state == ST_CHECK) && !match && (tries_left > 2'd1);
    buf_clr    = arm || (armed && !start_input) || (key_ok && is_clear) || retry;
  end

  entry_buffer u_entry_buffer (
    .clk    (clk),
    .rst_p  (rst_p),
    .clr    (buf_clr),
    .push   (buf_push),
    .digit  (key_value),
    .cnt    (entered_cnt),
    .digits (entry_digits)
  );

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state      <= ST_IDLE;
      // A start_input level held through reset is not an arm event; it must toggle.
      start_q    <= start_input;
      success    <= 1'b0;
      fail       <= 1'b0;
      err        <= 1'b0;
      tries_left <= 2'(MAX_TRIES);
      err_cnt    <= '0;
      code_q     <= '0;
    end else begin
      start_q <= start_input;
      case (state)
        ST_IDLE, ST_SUCCESS, ST_FAIL: begin
          if (start_rise) begin
            state      <= ST_ENTRY;
            success    <= 1'b0;
            fail       <= 1'b0;
            tries_left <= 2'(MAX_TRIES);
            for (int i = 0; i < CODE_LEN; i++) begin
              code_q[i*4 +: 4] <= code_digit(seed, i);
            end
          end
        end

        ST_ENTRY, ST_CHECK, ST_ERR: begin
          if (!start_input) begin
            state <= ST_IDLE;
            err   <= 1'b0;
          end else if (timeout) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
            err   <= 1'b0;
          end else begin
            case (state)
              ST_ENTRY: begin
                if (buf_push && last_slot) state <= ST_CHECK;
              end
              ST_CHECK: begin
                if (match) begin
                  state   <= ST_SUCCESS;
                  success <= 1'b1;
                end else if (tries_left > 2'd1) begin
                  state      <= ST_ERR;
                  tries_left <= tries_left - 2'd1;
                  err        <= 1'b1;
                  err_cnt    <= '0;
                end else begin
                  state      <= ST_FAIL;
                  tries_left <= 2'd0;
                  fail       <= 1'b1;
                end
              end
              ST_ERR: begin
                if (err_cnt == ERR_W'(ERR_CYCLES - 1)) begin
                  state <= ST_ENTRY;
                  err   <= 1'b0;
                end else begin
                  err_cnt <= err_cnt + 1'b1;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end

        default: begin
          state   <= ST_IDLE;
          success <= 1'b0;
          fail    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/passwd_check.md
Name: passwd_check

Overview:
- Password input/verification stage. It sits directly downstream of the game controller's `startInput`/`random` outputs.
- It derives the 4-digit bomb code from the 5-bit `random` seed, collects keypad digits, and compares the entry with the code.
- It drives the `insuccess`/`infail` levels that the controller uses to shut down the bomb display and the countdown.
- It also takes the 20 s countdown expiry as a fail source.

Parameters:
- CODE_LEN, 4, number of digits in the code and in the entry buffer.
- MAX_TRIES, 3, wrong complete entries allowed before fail (the MAX_TRIES-th wrong entry fails).
- ERR_CYCLES, 50_000_000, cycles the error indication is held after a wrong entry (1 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_p  in  1  synchronous, active-high reset.
- start_input  in  1  enable level from the controller (`startInput`).
- seed  in  5  code seed (`random`), sampled only on the arm event.
- timeout  in  1  countdown expired, level.
- key_valid  in  1  one-cycle strobe from the debounced keypad.
- key_value  in  4  key code: 0-9 are digits, 4'hC is clear; all other values are ignored.
- success  out  1  level, to `insuccess`.
- fail  out  1  level, to `infail`.
- err  out  1  high during error hold.
- entered_cnt  out  3  number of digits currently in the buffer (0..CODE_LEN).
- entry_digits  out  4*CODE_LEN  entered digits for display; digit 0 is in the LSBs; unentered slots read 4'hF.
- tries_left  out  2  remaining attempts.

Behaviour:
- Reset (rst_p=1 at an edge):
  - state goes to IDLE.
  - success, fail and err = 0; entered_cnt = 0.
  - entry_digits = all 4'hF; tries_left = MAX_TRIES.
  - rst_p has priority over every other input.
- States: IDLE, ENTRY, CHECK, ERR, SUCCESS, FAIL.
- IDLE → ENTRY: on the rising edge of start_input (registered previous value 0, current value 1).
  - Code digits are latched the same cycle: code[i] = (seed + OFFSET[i]) mod 10, with OFFSET = {0,3,6,9}.
  - The buffer is cleared and tries_left is set to MAX_TRIES.
- ENTRY, key handling:
  - key_valid with a digit: store at slot entered_cnt and increment entered_cnt.
  - When entered_cnt reaches CODE_LEN, go to CHECK next cycle. Keys arriving in CHECK/ERR/SUCCESS/FAIL are dropped.
  - Clear key: entered_cnt = 0 and buffer = all F; tries_left is unaffected.
  - Any other key_value is ignored.
- CHECK (exactly 1 cycle), full compare of the buffer with the code:
  - Match → SUCCESS; success=1 from the next cycle.
  - Mismatch with tries_left > 1 → decrement tries_left, clear the buffer, go to ERR with err=1.
  - Mismatch with tries_left = 1 → tries_left=0, go to FAIL.
- ERR: hold err=1 for ERR_CYCLES cycles, then err=0 and return to ENTRY. The error counter is cleared on entry to ERR.
- Timeout:
  - timeout=1 in ENTRY, CHECK or ERR → FAIL next cycle.
  - Timeout has priority over a same-cycle CHECK match and over a key.
  - Ignored in IDLE, SUCCESS and FAIL.
- SUCCESS and FAIL are terminal and sticky. The outputs hold even when start_input falls (the controller drops start_input in response to these outputs).
  - Left only by rst_p or by a new start_input rising edge, which re-arms as IDLE → ENTRY does and clears success/fail.
- start_input falling in ENTRY, CHECK or ERR: return to IDLE next cycle.
  - Buffer is cleared, err=0, and success/fail stay 0.
- success and fail are never both 1.

Decomposition:
- Shared package bomb_pkg holds:
  - the state enum;
  - CODE_LEN;
  - the OFFSET constant array;
  - the function `code_digit(seed, i)`.
- The code-display stage uses the same `code_digit` function so the shown code and the checked code agree.
- One natural sub-module, `entry_buffer`: digit shift-in, clear and count, with a 4*CODE_LEN display output. The FSM and compare stay in passwd_check.

Test Plan (ERR_CYCLES=8 in the bench):
- Correct entry:
  - Stimulus: seed=7, raise start_input; keys 7,0,3,6.
  - Response: entered_cnt goes 1..4, then CHECK, then success=1 two cycles after the 4th key_valid; fail=0.
  - Dropping start_input afterwards leaves success=1.
- Wrong entries:
  - Stimulus: seed=7; enter 1,2,3,4 three times.
  - Response: err=1 for 8 cycles after the 1st and 2nd attempts, with tries_left 2 then 1; the 3rd attempt gives fail=1 and tries_left=0.
- Clear and invalid keys:
  - Stimulus: keys 7, 4'hA, 0, 4'hC, then 7,0,3,6.
  - Response: entered_cnt reads 1, 1, 2, 0, and the final entry succeeds with tries_left=3.
- Timeout priority:
  - Stimulus: assert timeout in the same cycle as CHECK of a correct code.
  - Response: fail=1, success=0.
- Abort and re-arm:
  - Stimulus: after 2 keys, drop start_input.
  - Response: IDLE next cycle, entered_cnt=0, entry_digits=16'hFFFF.
  - Re-raise start_input with seed=2: the code becomes 2,5,8,1 and the old buffer is gone.
- Reset mid-ERR:
  - Stimulus: pulse rst_p during ERR.
  - Response: err=0, tries_left=3, IDLE the next cycle; key_valid is ignored until the start_input rising edge.
